// File: rtl/dma_cmd_pkg.sv
// Shared definitions for the DMA command stream parser.
// Holds the header opcode encoding, the opcode field geometry and the
// parser FSM state encoding. No ports; imported by dma_cmd_stream_parser.
package dma_cmd_pkg;

    // Opcode field: the top OP_W bits of header beat 0. The remaining low
    // bits of that beat carry the byte count.
    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
    localparam logic [OP_W-1:0] OP_STORE = 4'd1;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_STORE,
        ST_STORE_WAIT,
        ST_LOAD
    } state_e;

endpackage

// File: rtl/dma_cmd_stream_parser.sv
// Command front end for a write/read AxisToAxiAdapter pair.
// Parses a single AXI-Stream of commands (header, address, optional store
// payload), issues the adapter address requests, forwards store payload to
// the write adapter and passes load data from the read adapter to m_axis.
// Ports:
//   aclk, resetn             clock, asynchronous active-low reset
//   s_cmd_*                  command/payload input stream
//   wr_a*, wr_x*             write adapter request and payload
//   rd_a*, rd_x*             read adapter request and load data
//   m_axis_*                 load data output stream
//   busy, error, error_clear status: command active, sticky error, clear
module dma_cmd_stream_parser
    import dma_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = 4
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] s_cmd_tdata,
    input  logic [STRB_WIDTH-1:0] s_cmd_tstrb,
    input  logic                  s_cmd_tlast,
    input  logic                  s_cmd_tvalid,
    output logic                  s_cmd_tready,
    output logic                  wr_avalid,
    output logic [ADDR_WIDTH-1:0] wr_aaddr,
    output logic [ADDR_WIDTH-1:0] wr_abytes,
    input  logic                  wr_aready,
    output logic [DATA_WIDTH-1:0] wr_xdata,
    output logic [STRB_WIDTH-1:0] wr_xstrb,
    output logic                  wr_xlast,
    output logic                  wr_xvalid,
    input  logic                  wr_xready,
    output logic                  rd_avalid,
    output logic [ADDR_WIDTH-1:0] rd_aaddr,
    output logic [ADDR_WIDTH-1:0] rd_abytes,
    input  logic                  rd_aready,
    input  logic [DATA_WIDTH-1:0] rd_xdata,
    input  logic [STRB_WIDTH-1:0] rd_xstrb,
    input  logic                  rd_xlast,
    input  logic                  rd_xvalid,
    output logic                  rd_xready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [STRB_WIDTH-1:0] m_axis_tstrb,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  error,
    input  logic                  error_clear
);

    localparam int BPB       = DATA_WIDTH / 8;
    localparam int BPB_SHIFT = $clog2(BPB);
    localparam int CW        = ADDR_WIDTH + 1;   // beat counter width

    state_e                state_q, state_d;
    logic [OP_W-1:0]       op_q, op_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         rem_q, rem_d;
    logic                  wr_avalid_q, wr_avalid_d;
    logic                  rd_avalid_q, rd_avalid_d;
    logic                  error_q, error_d;
    logic                  drain_q, drain_d;     // discarding beats up to tlast
    logic                  wr_done_q, wr_done_d; // write-done seen during STORE

    logic                  cmd_hs;
    logic                  set_err;
    logic                  rem_nz;
    logic [OP_W-1:0]       hdr_op;
    logic [ADDR_WIDTH-1:0] hdr_len;
    logic [CW-1:0]         len_beats;

    assign cmd_hs    = s_cmd_tvalid && s_cmd_tready;
    assign rem_nz    = (rem_q != '0);
    assign hdr_op    = s_cmd_tdata[DATA_WIDTH-1 -: OP_W];
    assign hdr_len   = ADDR_WIDTH'(s_cmd_tdata[DATA_WIDTH-OP_W-1:0]);
    // ceil(len / BPB) with one spare bit so len near the top cannot wrap.
    assign len_beats = (CW'(len_q) + CW'(BPB - 1)) >> BPB_SHIFT;

    // Payload and load data buses are wired straight through; only the
    // valid/ready qualifiers depend on the state.
    assign wr_xdata     = s_cmd_tdata;
    assign wr_xstrb     = s_cmd_tstrb;
    assign m_axis_tdata = rd_xdata;
    assign m_axis_tstrb = rd_xstrb;
    assign m_axis_tlast = rd_xlast;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        len_d         = len_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        wr_avalid_d   = wr_avalid_q;
        rd_avalid_d   = rd_avalid_q;
        drain_d       = drain_q;
        wr_done_d     = wr_done_q;
        set_err       = 1'b0;
        s_cmd_tready  = 1'b0;
        wr_xvalid     = 1'b0;
        wr_xlast      = 1'b0;
        rd_xready     = 1'b0;
        m_axis_tvalid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                s_cmd_tready = 1'b1;
                if (cmd_hs) begin
                    if (drain_q) begin
                        if (s_cmd_tlast) drain_d = 1'b0;
                    end else begin
                        op_d  = hdr_op;
                        len_d = hdr_len;
                        if (hdr_op != OP_NOP && hdr_op != OP_STORE && hdr_op != OP_LOAD)
                            set_err = 1'b1;
                        // A one-beat packet has no address: reject it here.
                        if (s_cmd_tlast) set_err = 1'b1;
                        else             state_d = ST_ADDR;
                    end
                end
            end

            ST_ADDR: begin
                s_cmd_tready = 1'b1;
                if (cmd_hs) begin
                    addr_d = s_cmd_tdata[ADDR_WIDTH-1:0];
                    if (op_q == OP_STORE && len_q != '0) begin
                        state_d     = ST_STORE;
                        rem_d       = len_beats;
                        wr_avalid_d = 1'b1;
                        wr_done_d   = 1'b0;
                    end else if (op_q == OP_LOAD && len_q != '0) begin
                        state_d     = ST_LOAD;
                        rd_avalid_d = 1'b1;
                    end else begin
                        // Nothing to issue; a packet that keeps going is
                        // malformed and its tail is dropped.
                        state_d = ST_IDLE;
                        if (!s_cmd_tlast) begin
                            set_err = 1'b1;
                            drain_d = 1'b1;
                        end
                    end
                end
            end

            ST_STORE: begin
                wr_xvalid    = s_cmd_tvalid && rem_nz;
                s_cmd_tready = wr_xready && rem_nz;
                wr_xlast     = (rem_q == CW'(1));
                // The write adapter may finish before the last beat leaves
                // here; remember it so STORE_WAIT is skipped.
                if (wr_aready) begin
                    wr_avalid_d = 1'b0;
                    wr_done_d   = 1'b1;
                end
                if (cmd_hs) begin
                    rem_d = rem_q - CW'(1);
                    if (s_cmd_tlast != wr_xlast) set_err = 1'b1;
                    if (rem_q == CW'(1))
                        state_d = (wr_done_q || wr_aready) ? ST_IDLE : ST_STORE_WAIT;
                end
            end

            ST_STORE_WAIT: begin
                if (wr_aready) begin
                    wr_avalid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            ST_LOAD: begin
                rd_xready     = m_axis_tready;
                m_axis_tvalid = rd_xvalid;
                if (rd_aready) begin
                    rd_avalid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        error_d = error_q || set_err;
        if (error_clear) error_d = 1'b0;   // clear wins over a same-cycle set
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            len_q       <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            wr_avalid_q <= 1'b0;
            rd_avalid_q <= 1'b0;
            error_q     <= 1'b0;
            drain_q     <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            wr_avalid_q <= wr_avalid_d;
            rd_avalid_q <= rd_avalid_d;
            error_q     <= error_d;
            drain_q     <= drain_d;
            wr_done_q   <= wr_done_d;
        end
    end

    assign wr_avalid = wr_avalid_q;
    assign wr_aaddr  = addr_q;
    assign wr_abytes = len_q;
    assign rd_avalid = rd_avalid_q;
    assign rd_aaddr  = addr_q;
    assign rd_abytes = len_q;
    assign busy      = (state_q != ST_IDLE);
    assign error     = error_q;

endmodule

// File: tb/tb_dma_cmd_stream_parser.sv
// Self-checking bench for dma_cmd_stream_parser: scoreboard queues for
// store payload, load data and adapter requests, a table of short
// command vectors, and hand-written multi-cycle sequences.
module tb_dma_cmd_stream_parser;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic          aclk = 1'b0;
    logic          resetn;
    logic [DW-1:0] s_cmd_tdata;
    logic [SW-1:0] s_cmd_tstrb;
    logic          s_cmd_tlast, s_cmd_tvalid, s_cmd_tready;
    logic          wr_avalid, wr_aready;
    logic [AW-1:0] wr_aaddr, wr_abytes;
    logic [DW-1:0] wr_xdata;
    logic [SW-1:0] wr_xstrb;
    logic          wr_xlast, wr_xvalid, wr_xready;
    logic          rd_avalid, rd_aready;
    logic [AW-1:0] rd_aaddr, rd_abytes;
    logic [DW-1:0] rd_xdata;
    logic [SW-1:0] rd_xstrb;
    logic          rd_xlast, rd_xvalid, rd_xready;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic          busy, error, error_clear;

    dma_cmd_stream_parser #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
        .aclk(aclk), .resetn(resetn),
        .s_cmd_tdata(s_cmd_tdata), .s_cmd_tstrb(s_cmd_tstrb), .s_cmd_tlast(s_cmd_tlast),
        .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
        .wr_avalid(wr_avalid), .wr_aaddr(wr_aaddr), .wr_abytes(wr_abytes), .wr_aready(wr_aready),
        .wr_xdata(wr_xdata), .wr_xstrb(wr_xstrb), .wr_xlast(wr_xlast),
        .wr_xvalid(wr_xvalid), .wr_xready(wr_xready),
        .rd_avalid(rd_avalid), .rd_aaddr(rd_aaddr), .rd_abytes(rd_abytes), .rd_aready(rd_aready),
        .rd_xdata(rd_xdata), .rd_xstrb(rd_xstrb), .rd_xlast(rd_xlast),
        .rd_xvalid(rd_xvalid), .rd_xready(rd_xready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .busy(busy), .error(error), .error_clear(error_clear)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; logic last; } beat_t;
    typedef struct { logic is_wr; logic [AW-1:0] addr; logic [AW-1:0] bytes; } req_t;
    typedef struct {
        logic [3:0]  op;
        logic [27:0] len;
        logic        hdr_last;
        logic        addr_last;
        logic        exp_err;
    } vec_t;

    beat_t wr_q[$];
    beat_t m_q[$];
    req_t  req_q[$];

    int checks = 0;
    int errors = 0;
    logic tog_en = 1'b0;
    logic wr_av_prev = 1'b0;
    logic rd_av_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: handshakes are observed on the falling edge, half a
    // cycle before the rising edge that completes them.
    always @(negedge aclk) begin
        beat_t b;
        req_t  r;
        check("avalid_exclusive", 64'(wr_avalid && rd_avalid), 64'd0);
        if (wr_xvalid && wr_xready) begin
            if (wr_q.size() == 0) check("wr_x_unexpected_beat", 64'd1, 64'd0);
            else begin
                b = wr_q.pop_front();
                check("wr_xdata", 64'(wr_xdata), 64'(b.data));
                check("wr_xstrb", 64'(wr_xstrb), 64'(b.strb));
                check("wr_xlast", 64'(wr_xlast), 64'(b.last));
            end
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (m_q.size() == 0) check("m_axis_unexpected_beat", 64'd1, 64'd0);
            else begin
                b = m_q.pop_front();
                check("m_axis_tdata", 64'(m_axis_tdata), 64'(b.data));
                check("m_axis_tstrb", 64'(m_axis_tstrb), 64'(b.strb));
                check("m_axis_tlast", 64'(m_axis_tlast), 64'(b.last));
            end
        end
        if ((wr_avalid && !wr_av_prev) || (rd_avalid && !rd_av_prev)) begin
            if (req_q.size() == 0) check("unexpected_request", 64'd1, 64'd0);
            else begin
                r = req_q.pop_front();
                check("req_is_wr", 64'(wr_avalid), 64'(r.is_wr));
                check("req_addr", 64'(wr_avalid ? wr_aaddr : rd_aaddr), 64'(r.addr));
                check("req_bytes", 64'(wr_avalid ? wr_abytes : rd_abytes), 64'(r.bytes));
            end
        end
        wr_av_prev <= wr_avalid;
        rd_av_prev <= rd_avalid;
    end

    // wr_xready toggler used by the partial-beat store.
    initial forever begin
        @(posedge aclk);
        #1;
        if (tog_en) wr_xready = ~wr_xready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        int n = 0;
        s_cmd_tdata  = d;
        s_cmd_tstrb  = s;
        s_cmd_tlast  = l;
        s_cmd_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_cmd_tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!s_cmd_tready) check("cmd_handshake_timeout", 64'd1, 64'd0);
        @(posedge aclk);
        #1;
        s_cmd_tvalid = 1'b0;
    endtask

    task automatic send_hdr(input logic [3:0] op, input logic [27:0] len, input logic l);
        send_beat({op, len}, 4'hF, l);
    endtask

    task automatic pulse_wr_aready(input int delay);
        cyc(delay);
        check("wr_avalid_held", 64'(wr_avalid), 64'd1);
        wr_aready = 1'b1;
        cyc(1);
        wr_aready = 1'b0;
    endtask

    task automatic push_req(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] by);
        req_t r;
        r.is_wr = w; r.addr = a; r.bytes = by;
        req_q.push_back(r);
    endtask

    task automatic do_store(input logic [AW-1:0] addr, input logic [27:0] len,
                            input int nbeats, input int ack_delay);
        beat_t b;
        push_req(1'b1, addr, AW'(len));
        send_hdr(4'd1, len, 1'b0);
        check("store_busy_after_hdr", 64'(busy), 64'd1);
        send_beat(addr, 4'hF, 1'b0);
        check("store_wr_avalid_next_cycle", 64'(wr_avalid), 64'd1);
        for (int i = 0; i < nbeats; i++) begin
            b.data = $urandom;
            b.strb = 4'(i + 3);
            b.last = (i == nbeats - 1);
            wr_q.push_back(b);
            send_beat(b.data, b.strb, b.last);
        end
        pulse_wr_aready(ack_delay);
        check("store_wr_avalid_dropped", 64'(wr_avalid), 64'd0);
        check("store_idle", 64'(busy), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        beat_t b;
        vecs[0] = '{op: 4'd0, len: 28'd4,  hdr_last: 1'b0, addr_last: 1'b1, exp_err: 1'b0};
        vecs[1] = '{op: 4'd1, len: 28'd0,  hdr_last: 1'b0, addr_last: 1'b1, exp_err: 1'b0};
        vecs[2] = '{op: 4'd2, len: 28'd0,  hdr_last: 1'b0, addr_last: 1'b1, exp_err: 1'b0};
        vecs[3] = '{op: 4'd3, len: 28'd4,  hdr_last: 1'b0, addr_last: 1'b1, exp_err: 1'b1};
        vecs[4] = '{op: 4'd1, len: 28'd8,  hdr_last: 1'b1, addr_last: 1'b0, exp_err: 1'b1};
        vecs[5] = '{op: 4'd0, len: 28'd0,  hdr_last: 1'b0, addr_last: 1'b1, exp_err: 1'b0};

        resetn = 1'b0;
        s_cmd_tdata = '0; s_cmd_tstrb = '0; s_cmd_tlast = 1'b0; s_cmd_tvalid = 1'b0;
        wr_aready = 1'b0; wr_xready = 1'b1;
        rd_aready = 1'b0; rd_xdata = '0; rd_xstrb = '0; rd_xlast = 1'b0; rd_xvalid = 1'b0;
        m_axis_tready = 1'b1; error_clear = 1'b0;
        cyc(3);
        check("rst_wr_avalid", 64'(wr_avalid), 64'd0);
        check("rst_rd_avalid", 64'(rd_avalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_tready", 64'(s_cmd_tready), 64'd1);
        check("rst_wr_xvalid", 64'(wr_xvalid), 64'd0);
        resetn = 1'b1;
        cyc(2);

        // Basic store: 16 bytes, done pulse 10 cycles after the payload.
        do_store(32'h1000, 28'd16, 4, 10);
        check("store16_error", 64'(error), 64'd0);

        // 6 bytes = 2 beats, with wr_xready toggling every cycle.
        tog_en = 1'b1;
        do_store(32'h1800, 28'd6, 2, 2);
        tog_en = 1'b0;
        wr_xready = 1'b1;
        check("store6_all_beats_used", 64'(wr_q.size()), 64'd0);
        check("store6_error", 64'(error), 64'd0);

        // Load 32 bytes with a 3-cycle m_axis stall on beat 3.
        push_req(1'b0, 32'h2000, 32'd32);
        send_hdr(4'd2, 28'd32, 1'b0);
        send_beat(32'h2000, 4'hF, 1'b1);
        check("load_rd_avalid", 64'(rd_avalid), 64'd1);
        check("load_tready_low", 64'(s_cmd_tready), 64'd0);
        for (int i = 0; i < 8; i++) begin
            int n = 0;
            b.data = 32'hA500_0000 + 32'(i);
            b.strb = 4'(15 - i);
            b.last = (i == 7);
            m_q.push_back(b);
            rd_xdata = b.data; rd_xstrb = b.strb; rd_xlast = b.last; rd_xvalid = 1'b1;
            if (i == 3) begin
                m_axis_tready = 1'b0;
                cyc(3);
                check("load_stall_valid", 64'(m_axis_tvalid), 64'd1);
                check("load_stall_ready", 64'(rd_xready), 64'd0);
                m_axis_tready = 1'b1;
            end
            @(negedge aclk);
            while (!rd_xready && n < 200) begin
                @(negedge aclk);
                n++;
            end
            if (!rd_xready) check("load_handshake_timeout", 64'd1, 64'd0);
            @(posedge aclk);
            #1;
        end
        rd_xvalid = 1'b0;
        rd_xlast  = 1'b0;
        cyc(2);
        check("load_avalid_before_done", 64'(rd_avalid), 64'd1);
        rd_aready = 1'b1;
        cyc(1);
        rd_aready = 1'b0;
        check("load_rd_avalid_dropped", 64'(rd_avalid), 64'd0);
        check("load_idle", 64'(busy), 64'd0);
        check("load_wr_avalid", 64'(wr_avalid), 64'd0);

        // Unknown opcode is a NOP with error; the next store still decodes.
        send_hdr(4'd7, 28'd4, 1'b0);
        send_beat(32'hDEAD_BEEF, 4'hF, 1'b1);
        check("badop_error", 64'(error), 64'd1);
        check("badop_idle", 64'(busy), 64'd0);
        do_store(32'h3000, 28'd8, 2, 3);
        check("badop_error_sticky", 64'(error), 64'd1);
        error_clear = 1'b1;
        cyc(1);
        error_clear = 1'b0;
        check("error_cleared", 64'(error), 64'd0);

        // Short command table: nothing is ever issued.
        foreach (vecs[i]) begin
            send_hdr(vecs[i].op, vecs[i].len, vecs[i].hdr_last);
            check("vec_busy_after_hdr", 64'(busy), 64'(!vecs[i].hdr_last));
            if (!vecs[i].hdr_last) begin
                send_beat(32'h0000_4000 + 32'(i), 4'hF, vecs[i].addr_last);
                check("vec_busy_after_addr", 64'(busy), 64'd0);
            end
            check("vec_error", 64'(error), 64'(vecs[i].exp_err));
            check("vec_no_request", 64'(wr_avalid || rd_avalid), 64'd0);
            error_clear = 1'b1;
            cyc(1);
            error_clear = 1'b0;
        end

        // NOP without tlast: the rest of the packet is drained, even a
        // beat that looks like a STORE header.
        send_hdr(4'd0, 28'd4, 1'b0);
        send_beat(32'h0, 4'hF, 1'b0);
        check("drain_error", 64'(error), 64'd1);
        send_hdr(4'd1, 28'd16, 1'b0);
        check("drain_no_decode", 64'(busy), 64'd0);
        send_beat(32'h5555_5555, 4'hF, 1'b1);
        check("drain_done_idle", 64'(busy), 64'd0);
        error_clear = 1'b1;
        cyc(1);
        error_clear = 1'b0;
        do_store(32'h4400, 28'd4, 1, 0);
        check("after_drain_error", 64'(error), 64'd0);

        // Write-done arrives before the last payload beat.
        push_req(1'b1, 32'h6000, 32'd8);
        send_hdr(4'd1, 28'd8, 1'b0);
        send_beat(32'h6000, 4'hF, 1'b0);
        b = '{data: 32'h1111_2222, strb: 4'hF, last: 1'b0};
        wr_q.push_back(b);
        send_beat(b.data, b.strb, b.last);
        wr_aready = 1'b1;
        cyc(1);
        wr_aready = 1'b0;
        check("early_ack_avalid_dropped", 64'(wr_avalid), 64'd0);
        check("early_ack_still_busy", 64'(busy), 64'd1);
        b = '{data: 32'h3333_4444, strb: 4'h3, last: 1'b1};
        wr_q.push_back(b);
        send_beat(b.data, b.strb, b.last);
        check("early_ack_idle", 64'(busy), 64'd0);
        check("early_ack_error", 64'(error), 64'd0);

        // tlast on the wrong beat: beat count governs, error is flagged.
        push_req(1'b1, 32'h7000, 32'd8);
        send_hdr(4'd1, 28'd8, 1'b0);
        send_beat(32'h7000, 4'hF, 1'b0);
        wr_q.push_back('{data: 32'hAAAA_0001, strb: 4'hF, last: 1'b0});
        send_beat(32'hAAAA_0001, 4'hF, 1'b1);
        check("tlast_early_error", 64'(error), 64'd1);
        wr_q.push_back('{data: 32'hAAAA_0002, strb: 4'hF, last: 1'b1});
        send_beat(32'hAAAA_0002, 4'hF, 1'b0);
        pulse_wr_aready(1);
        check("tlast_mismatch_idle", 64'(busy), 64'd0);
        error_clear = 1'b1;
        cyc(1);
        error_clear = 1'b0;

        // Asynchronous reset in the middle of a store.
        push_req(1'b1, 32'h8000, 32'd16);
        send_hdr(4'd1, 28'd16, 1'b0);
        send_beat(32'h8000, 4'hF, 1'b0);
        for (int i = 0; i < 2; i++) begin
            b = '{data: 32'hB000_0000 + 32'(i), strb: 4'hF, last: 1'b0};
            wr_q.push_back(b);
            send_beat(b.data, b.strb, b.last);
        end
        s_cmd_tdata = 32'hB000_0002; s_cmd_tlast = 1'b0; s_cmd_tvalid = 1'b1;
        #1;
        check("pre_reset_wr_xvalid", 64'(wr_xvalid), 64'd1);
        #1;
        resetn = 1'b0;
        #1;
        check("async_rst_wr_avalid", 64'(wr_avalid), 64'd0);
        check("async_rst_wr_xvalid", 64'(wr_xvalid), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_tready", 64'(s_cmd_tready), 64'd1);
        s_cmd_tvalid = 1'b0;
        cyc(2);
        resetn = 1'b1;
        cyc(1);
        do_store(32'h9000, 28'd12, 3, 4);
        check("post_reset_error", 64'(error), 64'd0);

        cyc(3);
        check("wr_queue_empty", 64'(wr_q.size()), 64'd0);
        check("m_queue_empty", 64'(m_q.size()), 64'd0);
        check("req_queue_empty", 64'(req_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_cmd_stream_parser.md
Name: dma_cmd_stream_parser

Overview:
Upstream command front end for a pair of AxisToAxiAdapter instances: one in the write direction, one in the read direction. It consumes a single AXI-Stream command stream. Each command is a header, an address word and, for stores, the payload. It issues the adapter address requests, forwards store payload into the write adapter, and routes load data from the read adapter to an output stream. Completion is signalled by the adapters' one-cycle s_aready pulse.

Parameters:
DATA_WIDTH, 32, width of every data bus; BPB = DATA_WIDTH/8 bytes per beat.
ADDR_WIDTH, 32, width of addresses and byte counts.
STRB_WIDTH, 4, strobe width, equal to DATA_WIDTH/8.

Ports:
aclk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
s_cmd_tdata  in  DATA_WIDTH  command/payload stream data
s_cmd_tstrb  in  STRB_WIDTH  payload byte strobes (ignored on header beats)
s_cmd_tlast  in  1  end of command packet
s_cmd_tvalid  in  1  stream valid
s_cmd_tready  out  1  stream ready
wr_avalid  out  1  write request; goes to write adapter s_avalid
wr_aaddr  out  ADDR_WIDTH  write start address
wr_abytes  out  ADDR_WIDTH  write byte count
wr_aready  in  1  write-done pulse from write adapter s_aready
wr_xdata  out  DATA_WIDTH  store payload to write adapter
wr_xstrb  out  STRB_WIDTH  store payload strobes
wr_xlast  out  1  last payload beat
wr_xvalid  out  1  payload valid
wr_xready  in  1  payload ready
rd_avalid  out  1  read request; goes to read adapter s_avalid
rd_aaddr  out  ADDR_WIDTH  read start address
rd_abytes  out  ADDR_WIDTH  read byte count
rd_aready  in  1  read-done pulse
rd_xdata  in  DATA_WIDTH  load data from read adapter
rd_xstrb  in  STRB_WIDTH  load strobes
rd_xlast  in  1  load last
rd_xvalid  in  1  load valid
rd_xready  out  1  load ready
m_axis_tdata  out  DATA_WIDTH  load data out
m_axis_tstrb  out  STRB_WIDTH  load strobes out
m_axis_tlast  out  1  load last out
m_axis_tvalid  out  1  load valid out
m_axis_tready  in  1  load ready
busy  out  1  a command is in progress
error  out  1  sticky protocol error
error_clear  in  1  clears error (synchronous)

Behaviour:
- Header beat 0 fields: op = tdata[DATA_WIDTH-1 -: 4]; len = tdata[DATA_WIDTH-5:0], zero-extended to ADDR_WIDTH. Beat 1 = address (low ADDR_WIDTH bits).
- Opcodes: 0 NOP, 1 STORE, 2 LOAD. Any other opcode is handled as NOP and sets error.
- Payload beat count: beats = ceil(len/BPB), computed in ADDR_WIDTH+1 bits.
- FSM states: IDLE, ADDR, STORE, STORE_WAIT, LOAD.
- IDLE: s_cmd_tready=1. On a handshake, latch op and len, then go to ADDR.
  - If tlast is set on this beat: set error, stay in IDLE.
- ADDR: s_cmd_tready=1. On a handshake, latch the address.
  - NOP, or len==0: return to IDLE, issue nothing. If tlast=0, set error and drop beats until a tlast handshake (DRAIN behaviour inside IDLE: header decode is inhibited until tlast).
  - STORE: go to STORE. wr_avalid is registered high on the next cycle, with wr_aaddr/wr_abytes stable.
  - LOAD: go to LOAD. rd_avalid is registered high on the next cycle.
- STORE: the payload path is combinational.
  - wr_xdata/strb = s_cmd_tdata/tstrb; wr_xvalid = s_cmd_tvalid && remaining!=0; s_cmd_tready = wr_xready && remaining!=0.
  - remaining is decremented on each handshake. wr_xlast = (remaining==1).
  - If s_cmd_tlast mismatches wr_xlast on a handshake, set error. Beat counting governs; tlast does not.
  - When remaining reaches 0, go to STORE_WAIT with s_cmd_tready=0.
- STORE_WAIT: hold wr_avalid until the cycle wr_aready=1 is sampled. Then drop wr_avalid and go to IDLE on the next cycle. A wr_aready pulse arriving while still in STORE is also accepted; in that case go to IDLE once remaining==0.
- LOAD: rd_x → m_axis is combinational pass-through (rd_xready = m_axis_tready; valid/data/strb/last copied). s_cmd_tready=0. Hold rd_avalid until rd_aready is sampled high, then go to IDLE.
- busy = (state != IDLE).
- error is set by the events above. error_clear has priority over a same-cycle set.
- Reset (asynchronous, any state): state=IDLE, all *_avalid=0, remaining=0, error=0, drain flag=0. Combinational outputs follow from state, so wr_xvalid=0 and s_cmd_tready=1.
- Never assert wr_avalid and rd_avalid together. At most one command is outstanding.

Decomposition:
- Shared package dma_cmd_pkg holds:
  - Opcode constants OP_NOP/OP_STORE/OP_LOAD.
  - Op field width (4) and position.
  - FSM state encoding.
- No sub-module: the adapters are instantiated by the parent, not inside this block.

Test Plan:
- STORE: len=16, addr=0x1000, 4 payload beats with tlast on the 4th; wr_aready pulse 10 cycles later → wr_avalid high from the cycle after the address beat until the pulse; 4 wr_x beats, wr_xlast on beat 4; error=0; back to IDLE.
- STORE len=6 (BPB=4) with wr_xready toggling every cycle → exactly 2 payload beats forwarded, wr_abytes=6, no beat lost or duplicated.
- LOAD len=32, addr=0x2000: 8 rd_x beats with m_axis_tready stalling 3 cycles → m_axis carries all 8 beats in order; rd_avalid drops after the rd_aready pulse; wr_avalid stays 0.
- op=7 header with 1 junk beat plus tlast → error=1, no request issued, next STORE decodes correctly; error_clear → error=0.
- STORE len=0 and NOP → no request, returns to IDLE after 2 beats; busy high for exactly those beats.
- resetn asserted mid-STORE after 2 of 4 beats → wr_avalid and wr_xvalid fall immediately (asynchronously), state=IDLE; a new command afterwards executes normally.
